// File: rtl/rx_packet_sequencer_if.sv
// rtl/rx_packet_sequencer_if.sv - protocol FSM / unstuffer / decoder signals for the rx packet sequencer
interface rx_packet_sequencer_if #(
    parameter int CNT_W = 11
);
    logic             rx_arm;
    logic             rx_abort;
    logic             sync_seen;
    logic             eop_seen;
    logic             start_unstuffer;
    logic             end_unstuffer;
    logic             dec_bit;
    logic             dec_valid;
    logic             end_decode;
    logic             busy;
    logic [3:0]       pid;
    logic             pid_ok;
    logic             pid_error;
    logic             babble;
    logic             rx_timeout;
    logic             rx_done;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output rx_arm, rx_abort, sync_seen, eop_seen, dec_bit, dec_valid, end_decode,
        input  start_unstuffer, end_unstuffer, busy, pid, pid_ok, pid_error,
               babble, rx_timeout, rx_done, bit_count
    );

    modport slave (
        input  rx_arm, rx_abort, sync_seen, eop_seen, dec_bit, dec_valid, end_decode,
        output start_unstuffer, end_unstuffer, busy, pid, pid_ok, pid_error,
               babble, rx_timeout, rx_done, bit_count
    );
endinterface

// File: rtl/rx_packet_sequencer.sv
// rtl/rx_packet_sequencer.sv - sequences unstuffer/decoder for one USB packet and checks its PID
module rx_packet_sequencer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_BITS       = 1100,
    parameter int CNT_W          = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    rx_packet_sequencer_if.slave bus
);
    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BITS);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_PID     = 3'd2;
    localparam logic [2:0] S_PAYLOAD = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       pid_q, pid_d;
    logic             pid_ok_q, pid_ok_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;
    logic             busy_q, busy_d;
    logic             start_unstuffer_q, start_unstuffer_d;
    logic             end_unstuffer_q, end_unstuffer_d;
    logic             pid_error_q, pid_error_d;
    logic             babble_q, babble_d;
    logic             rx_timeout_q, rx_timeout_d;
    logic             rx_done_q, rx_done_d;

    logic [7:0]       shift_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        state_d           = state_q;
        timer_d           = timer_q;
        shift_d           = shift_q;
        idx_d             = idx_q;
        pid_d             = pid_q;
        pid_ok_d          = pid_ok_q;
        bit_count_d       = bit_count_q;
        start_unstuffer_d = 1'b0;
        end_unstuffer_d   = 1'b0;
        pid_error_d       = 1'b0;
        babble_d          = 1'b0;
        rx_timeout_d      = 1'b0;
        rx_done_d         = 1'b0;
        // PID arrives LSB first, so new bits enter at the top and slide down
        shift_nxt         = {bus.dec_bit, shift_q[7:1]};
        cnt_nxt           = bit_count_q + CNT_W'(bus.dec_valid);

        case (state_q)
            S_IDLE: begin
                if (bus.rx_arm) begin
                    state_d     = S_ARMED;
                    timer_d     = '0;
                    pid_d       = '0;
                    pid_ok_d    = 1'b0;
                    bit_count_d = '0;
                end
            end
            S_ARMED: begin
                timer_d = timer_q + 1'b1;
                if (bus.rx_abort) begin
                    state_d = S_IDLE;
                end else if (bus.sync_seen) begin
                    state_d           = S_PID;
                    start_unstuffer_d = 1'b1;
                    idx_d             = '0;
                    shift_d           = '0;
                end else if (timer_q == TMR_LAST) begin
                    state_d      = S_IDLE;
                    rx_timeout_d = 1'b1;
                end
            end
            S_PID: begin
                if (bus.rx_abort) begin
                    state_d         = S_IDLE;
                    end_unstuffer_d = 1'b1;
                end else begin
                    if (bus.dec_valid) begin
                        shift_d = shift_nxt;
                        idx_d   = idx_q + 1'b1;
                    end
                    if (bus.dec_valid && idx_q == 3'd7) begin
                        if (shift_nxt[7:4] == ~shift_nxt[3:0]) begin
                            pid_d    = shift_nxt[3:0];
                            pid_ok_d = 1'b1;
                            if (bus.eop_seen) begin
                                state_d         = S_DRAIN;
                                timer_d         = '0;
                                end_unstuffer_d = 1'b1;
                            end else begin
                                state_d = S_PAYLOAD;
                            end
                        end else begin
                            state_d         = S_DRAIN;
                            timer_d         = '0;
                            pid_error_d     = 1'b1;
                            end_unstuffer_d = 1'b1;
                        end
                    end else if (bus.eop_seen) begin
                        state_d         = S_DRAIN;
                        timer_d         = '0;
                        pid_error_d     = 1'b1;
                        end_unstuffer_d = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (bus.rx_abort) begin
                    state_d         = S_IDLE;
                    end_unstuffer_d = 1'b1;
                end else begin
                    bit_count_d = cnt_nxt;
                    if (cnt_nxt == CNT_MAX) begin
                        state_d         = S_DRAIN;
                        timer_d         = '0;
                        babble_d        = 1'b1;
                        end_unstuffer_d = 1'b1;
                    end else if (bus.eop_seen) begin
                        state_d         = S_DRAIN;
                        timer_d         = '0;
                        end_unstuffer_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                timer_d = timer_q + 1'b1;
                if (bus.rx_abort) begin
                    state_d = S_IDLE;
                end else if (bus.end_decode) begin
                    state_d   = S_IDLE;
                    rx_done_d = 1'b1;
                end else if (timer_q == TMR_LAST) begin
                    state_d      = S_IDLE;
                    rx_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= S_IDLE;
            timer_q           <= '0;
            shift_q           <= '0;
            idx_q             <= '0;
            pid_q             <= '0;
            pid_ok_q          <= 1'b0;
            bit_count_q       <= '0;
            busy_q            <= 1'b0;
            start_unstuffer_q <= 1'b0;
            end_unstuffer_q   <= 1'b0;
            pid_error_q       <= 1'b0;
            babble_q          <= 1'b0;
            rx_timeout_q      <= 1'b0;
            rx_done_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            shift_q           <= shift_d;
            idx_q             <= idx_d;
            pid_q             <= pid_d;
            pid_ok_q          <= pid_ok_d;
            bit_count_q       <= bit_count_d;
            busy_q            <= busy_d;
            start_unstuffer_q <= start_unstuffer_d;
            end_unstuffer_q   <= end_unstuffer_d;
            pid_error_q       <= pid_error_d;
            babble_q          <= babble_d;
            rx_timeout_q      <= rx_timeout_d;
            rx_done_q         <= rx_done_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.pid             = pid_q;
    assign bus.pid_ok          = pid_ok_q;
    assign bus.bit_count       = bit_count_q;
    assign bus.start_unstuffer = start_unstuffer_q;
    assign bus.end_unstuffer   = end_unstuffer_q;
    assign bus.pid_error       = pid_error_q;
    assign bus.babble          = babble_q;
    assign bus.rx_timeout      = rx_timeout_q;
    assign bus.rx_done         = rx_done_q;
endmodule

// File: tb/tb_rx_packet_sequencer.sv
// tb/tb_rx_packet_sequencer.sv - table-driven and randomized bench for rx_packet_sequencer
module tb_rx_packet_sequencer;
    localparam int TMO   = 16;
    localparam int MAXB  = 32;
    localparam int CNT_W = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rx_packet_sequencer_if #(.CNT_W(CNT_W)) s ();

    rx_packet_sequencer #(.TIMEOUT_CYCLES(TMO), .MAX_BITS(MAXB), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(s.slave)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monotonic pulse totals plus values snapshotted when rx_done / babble fire
    int su_tot = 0, eu_tot = 0, err_tot = 0, bab_tot = 0, to_tot = 0, done_tot = 0;
    int cap_pid, cap_ok, cap_bits, cap_eu, bab_bits;
    always @(negedge clk) begin
        if (s.start_unstuffer) su_tot++;
        if (s.end_unstuffer)   eu_tot++;
        if (s.pid_error)       err_tot++;
        if (s.rx_timeout)      to_tot++;
        if (s.babble) begin
            bab_tot++;
            bab_bits = int'(s.bit_count);
        end
        if (s.rx_done) begin
            done_tot++;
            cap_pid  = int'(s.pid);
            cap_ok   = int'(s.pid_ok);
            cap_bits = int'(s.bit_count);
            cap_eu   = eu_tot;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit use_gaps = 1'b0;
    task automatic gap();
        if (use_gaps && $urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 2)) tick();
    endtask

    typedef struct {
        logic [7:0] pb;
        int         npid;
        int         npay;
        bit         eop8;
        int         abort_at;
        int         e_pid;
        bit         e_ok;
        int         e_bits;
        bit         e_err;
        bit         e_bab;
        bit         e_done;
    } vec_t;

    // Outcome derived from the packet description alone
    function automatic vec_t model(input logic [7:0] pb, input int npid, input int npay,
                                   input bit eop8, input int abort_at);
        vec_t v;
        bit pass;
        pass       = (npid == 8) && (pb[7:4] == ~pb[3:0]);
        v.pb       = pb;
        v.npid     = npid;
        v.npay     = npay;
        v.eop8     = eop8;
        v.abort_at = abort_at;
        v.e_ok     = pass;
        v.e_pid    = pass ? int'(pb[3:0]) : 0;
        v.e_err    = !pass;
        v.e_bab    = pass && (abort_at < 0) && (npay >= MAXB);
        v.e_bits   = !pass ? 0 : (npay >= MAXB ? MAXB : npay);
        v.e_done   = (abort_at < 0);
        return v;
    endfunction

    task automatic run_packet(input vec_t v, input int dec_delay);
        int su0, eu0, err0, bab0, to0, done0;
        bit aborted;
        bit eop_join;
        su0 = su_tot; eu0 = eu_tot; err0 = err_tot;
        bab0 = bab_tot; to0 = to_tot; done0 = done_tot;
        aborted  = 1'b0;
        eop_join = use_gaps ? 1'($urandom_range(0, 1)) : 1'b1;

        s.rx_arm = 1'b1; tick(); s.rx_arm = 1'b0;
        repeat (use_gaps ? $urandom_range(0, 5) : 1) tick();
        s.sync_seen = 1'b1; tick(); s.sync_seen = 1'b0;
        chk("start_unstuffer_after_sync", int'(s.start_unstuffer), 1);

        for (int i = 0; i < v.npid; i++) begin
            gap();
            s.dec_valid = 1'b1;
            s.dec_bit   = v.pb[i];
            s.eop_seen  = v.eop8 && (i == 7);
            tick();
            s.dec_valid = 1'b0;
            s.eop_seen  = 1'b0;
        end
        if (v.npid < 8) begin
            gap();
            s.eop_seen = 1'b1; tick(); s.eop_seen = 1'b0;
        end else if (!v.eop8) begin
            for (int i = 0; i < v.npay; i++) begin
                gap();
                s.dec_valid = 1'b1;
                s.dec_bit   = 1'($urandom_range(0, 1));
                if (i == v.abort_at) begin
                    s.rx_abort = 1'b1;
                    tick();
                    s.rx_abort  = 1'b0;
                    s.dec_valid = 1'b0;
                    aborted     = 1'b1;
                    break;
                end
                s.eop_seen = eop_join && (i == v.npay - 1);
                tick();
                s.dec_valid = 1'b0;
                s.eop_seen  = 1'b0;
            end
            if (!aborted && !(eop_join && v.npay > 0)) begin
                gap();
                s.eop_seen = 1'b1; tick(); s.eop_seen = 1'b0;
            end
        end

        repeat (aborted ? 3 : dec_delay) tick();
        s.end_decode = 1'b1; tick(); s.end_decode = 1'b0;
        repeat (2) tick();

        chk("start_unstuffer_count", su_tot - su0, 1);
        chk("end_unstuffer_count", eu_tot - eu0, 1);
        chk("pid_error_count", err_tot - err0, int'(v.e_err));
        chk("babble_count", bab_tot - bab0, int'(v.e_bab));
        chk("rx_timeout_count", to_tot - to0, 0);
        chk("rx_done_count", done_tot - done0, int'(v.e_done));
        chk("busy_after_packet", int'(s.busy), 0);
        if (v.e_done) begin
            chk("pid_at_done", cap_pid, v.e_pid);
            chk("pid_ok_at_done", cap_ok, int'(v.e_ok));
            chk("bit_count_at_done", cap_bits, v.e_bits);
            chk("end_unstuffer_before_done", cap_eu - eu0, 1);
        end
        if (v.e_bab) chk("bit_count_at_babble", bab_bits, MAXB);
    endtask

    vec_t tbl[6];

    initial begin
        int k, su0, eu0, to0;
        vec_t v;
        logic [7:0] pb;
        logic [3:0] nib;
        int npid, npay;
        bit eop8;

        tbl[0] = model(8'hD2, 8, 0, 1'b1, -1);
        tbl[1] = model(8'hC2, 8, 0, 1'b0, -1);
        tbl[2] = model(8'hC3, 8, 24, 1'b0, -1);
        tbl[3] = model(8'hD2, 5, 0, 1'b0, -1);
        tbl[4] = model(8'hB4, 8, 40, 1'b0, -1);
        tbl[5] = model(8'hE1, 8, 10, 1'b0, 5);

        s.rx_arm = 0; s.rx_abort = 0; s.sync_seen = 0; s.eop_seen = 0;
        s.dec_bit = 0; s.dec_valid = 0; s.end_decode = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", int'(s.busy), 0);
        chk("reset_pid", int'(s.pid), 0);
        chk("reset_pid_ok", int'(s.pid_ok), 0);
        chk("reset_bit_count", int'(s.bit_count), 0);
        chk("reset_pulses", int'({s.start_unstuffer, s.end_unstuffer, s.pid_error,
                                  s.babble, s.rx_timeout, s.rx_done}), 0);

        for (int i = 0; i < 6; i++) run_packet(tbl[i], 3);

        // ARMED timer expiry with no SYNC
        su0 = su_tot; to0 = to_tot;
        s.rx_arm = 1'b1; tick(); s.rx_arm = 1'b0;
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (s.rx_timeout) begin
                k = c;
                break;
            end
        end
        chk("armed_timeout_cycle", k, TMO);
        tick();
        chk("busy_after_timeout", int'(s.busy), 0);
        chk("timeout_count", to_tot - to0, 1);
        chk("no_start_on_timeout", su_tot - su0, 0);

        // Reset in the middle of the payload
        eu0 = eu_tot;
        s.rx_arm = 1'b1; tick(); s.rx_arm = 1'b0;
        s.sync_seen = 1'b1; tick(); s.sync_seen = 1'b0;
        pb = 8'hD2;
        for (int i = 0; i < 8; i++) begin
            s.dec_valid = 1'b1; s.dec_bit = pb[i]; tick();
        end
        for (int i = 0; i < 5; i++) begin
            s.dec_bit = 1'b1; tick();
        end
        chk("bit_count_before_rst", int'(s.bit_count), 5);
        rst = 1'b1; tick();
        s.dec_valid = 1'b0;
        chk("rst_outputs_zero", int'({s.busy, s.pid, s.pid_ok, s.bit_count, s.start_unstuffer,
                                      s.end_unstuffer, s.pid_error, s.babble, s.rx_timeout,
                                      s.rx_done}), 0);
        rst = 1'b0; tick();
        chk("no_end_unstuffer_on_rst", eu_tot - eu0, 0);

        // Randomized packets against the model
        use_gaps = 1'b1;
        for (int r = 0; r < 25; r++) begin
            nib  = 4'($urandom);
            pb   = ($urandom_range(0, 3) != 0) ? {~nib, nib} : 8'($urandom);
            npid = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : 8;
            eop8 = (npid == 8) && ($urandom_range(0, 4) == 0);
            npay = ((npid == 8) && !eop8 && (pb[7:4] == ~pb[3:0])) ? $urandom_range(0, MAXB - 1) : 0;
            v = model(pb, npid, npay, eop8, -1);
            run_packet(v, $urandom_range(0, 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rx_packet_sequencer.md
Name: rx_packet_sequencer

Overview:
- Receive-path controller that sequences the bit unstuffer and bit stream decoder for one USB packet at a time.
- Armed by the protocol FSM, it starts the unstuffer when SYNC completes and assembles and checks the 8-bit PID from the decoded bit stream.
- It counts payload bits, ends the unstuffer on EOP, babble or abort, and waits for the decoder to drain.
- It then reports a single completion or error status back to the protocol FSM.

Parameters:
TIMEOUT_CYCLES, 256, max cycles in ARMED waiting for sync_seen, and max cycles in DRAIN waiting for end_decode
MAX_BITS, 1100, payload bit count (after PID) at which the packet is declared babble
CNT_W, 11, width of bit_count; must hold MAX_BITS

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_arm  in  1  pulse from protocol FSM: expect a packet
rx_abort  in  1  pulse: abandon current packet
sync_seen  in  1  pulse from SYNC detector: next decoded bit is PID bit 0
eop_seen  in  1  pulse from line receiver: SE0 EOP detected
start_unstuffer  out  1  pulse to bit unstuffer: begin
end_unstuffer  out  1  pulse to bit unstuffer: stop accepting bits
dec_bit  in  1  decoded, unstuffed bit
dec_valid  in  1  dec_bit is valid this cycle
end_decode  in  1  pulse from decoder: pipeline drained
busy  out  1  high in any state except IDLE
pid  out  4  captured PID[3:0], held until next rx_arm
pid_ok  out  1  level: PID check passed, held until next rx_arm
pid_error  out  1  pulse: PID check failed or packet shorter than 8 bits
babble  out  1  pulse: payload reached MAX_BITS
rx_timeout  out  1  pulse: ARMED or DRAIN timer expired
rx_done  out  1  pulse: packet ended and decoder drained
bit_count  out  CNT_W  payload bits received, valid with rx_done

Behaviour:
- Every output is registered, and every pulse lasts exactly one cycle.
- On rst, all outputs are 0, pid is 0, all counters are 0, and the state is IDLE. rst mid-packet issues no end_unstuffer.
- States are IDLE, ARMED, PID, PAYLOAD, DRAIN.
- IDLE: on rx_arm, go to ARMED; clear timer, pid, pid_ok and bit_count.
- ARMED: timer increments each cycle.
  - On sync_seen, go to PID; start_unstuffer pulses the next cycle.
  - When timer reaches TIMEOUT_CYCLES-1 without sync_seen, pulse rx_timeout and go to IDLE.
  - If sync_seen arrives in the expiry cycle, it wins.
- PID: a 3-bit index counts dec_valid bits; bits are shifted in LSB first into an 8-bit register.
  - On the 8th valid bit, check reg[7:4] == ~reg[3:0].
    - Pass: pid <= reg[3:0], pid_ok <= 1, go to PAYLOAD.
    - Fail: pulse pid_error and end_unstuffer, go to DRAIN.
  - eop_seen before the 8th bit: pulse pid_error and end_unstuffer, go to DRAIN.
  - eop_seen in the same cycle as the 8th bit: the PID check is applied first. On pass, set pid_ok, pulse end_unstuffer and go straight to DRAIN (handshake packet, zero payload).
- PAYLOAD: bit_count increments on each dec_valid.
  - On eop_seen, pulse end_unstuffer and go to DRAIN. A dec_valid in the same cycle is still counted.
  - When bit_count reaches MAX_BITS, pulse babble and end_unstuffer, go to DRAIN. Further bits are not counted, so bit_count saturates at MAX_BITS.
- DRAIN: timer restarts at 0.
  - dec_valid is ignored.
  - On end_decode, pulse rx_done and go to IDLE.
  - When timer reaches TIMEOUT_CYCLES-1, pulse rx_timeout and go to IDLE with no rx_done.
- rx_abort:
  - In PID or PAYLOAD: pulse end_unstuffer, go to IDLE, no rx_done.
  - In ARMED or DRAIN: go to IDLE.
  - In IDLE: ignored.
  - rx_abort has priority over every other event in the same cycle.
- rx_arm while busy is ignored.
- end_unstuffer is pulsed at most once per packet.
- rx_done is only ever pulsed after end_unstuffer for the same packet.

Test Plan:
1. ACK: rx_arm, sync_seen, dec bits 0,1,0,0,1,0,1,1 (0xD2 LSB first), eop_seen with the 8th bit, end_decode 3 cycles later.
   - Required: start_unstuffer one cycle after sync_seen, then pid=0x2, pid_ok=1, bit_count=0.
   - Required: one end_unstuffer, then rx_done.
2. Bad PID: bits for 0xC2.
   - Required: pid_error pulse and end_unstuffer on the 8th bit, pid_ok=0.
   - Required: rx_done after end_decode.
3. DATA0: PID 0xC3, then 24 payload bits, eop_seen.
   - Required: pid=0x3, bit_count=24 at rx_done, no babble.
4. Timeout: TIMEOUT_CYCLES=16, rx_arm, no sync_seen.
   - Required: rx_timeout on the 16th cycle in ARMED, busy=0 next cycle, start_unstuffer never asserted.
5. Babble: MAX_BITS=32, valid PID, 40 payload bits.
   - Required: babble and end_unstuffer when bit_count hits 32; bit_count stays 32.
   - Required: rx_done after end_decode.
6. Abort/reset:
   - rx_abort at payload bit 5: end_unstuffer pulse, IDLE, no rx_done.
   - Separately, rst at payload bit 5: all outputs 0 next cycle, no end_unstuffer.
